input_conditioner_stage: RTL and testbench
==========================================

Name: input_conditioner_stage

Overview:
- Input conditioning stage directly upstream of the Moore next-state logic, which drives the two-flip-flop state register stage (inputY1/inputY2 -> outputy1/outputy2).
- Takes one raw asynchronous external input, such as a push-button or switch.
- Produces a synchronized, debounced level and single-cycle rise/fall pulses, so the Moore machine only sees clean, clock-aligned transitions.

Parameters:
- DEBOUNCE_CYCLES, 4: number of additional consecutive synchronized samples required after first detecting a change; legal range 1..2^CNT_W.
- CNT_W, 3: width of the debounce counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- inputClk  in  1  single system clock; all state updates on rising edge.
- inputR  in  1  synchronous reset, active-low; sampled on rising edge of inputClk.
- inputX  in  1  raw asynchronous input; may glitch/bounce at any time.
- outputX  out  1  debounced, synchronized level; registered.
- outputRise  out  1  one-cycle pulse when outputX goes 0->1; registered.
- outputFall  out  1  one-cycle pulse when outputX goes 1->0; registered.

Behaviour:
- Reset (inputR==0 at a rising edge):
  - sync1, sync2, counter, state <= 0 / LOW; outputX, outputRise, outputFall <= 0.
  - Reset dominates every other condition. No pulse is generated by reset, even from HIGH.
- Synchronizer: sync1 <= inputX; sync2 <= sync1. Only sync2 is used downstream.
- FSM, 4 states: LOW, RISING, HIGH, FALLING. Counter cnt[CNT_W-1:0].
  - LOW: sync2==1 -> RISING, cnt<=0. Else stay.
  - RISING:
    - sync2==0 -> LOW, cnt<=0 (glitch rejected, no output change).
    - sync2==1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, outputX<=1, outputRise<=1.
    - Otherwise cnt<=cnt+1.
  - HIGH: sync2==0 -> FALLING, cnt<=0. Else stay.
  - FALLING:
    - sync2==1 -> HIGH, cnt<=0 (glitch rejected).
    - sync2==0 and cnt==DEBOUNCE_CYCLES-1 -> LOW, outputX<=0, outputFall<=1.
    - Otherwise cnt<=cnt+1.
- Pulses: outputRise/outputFall are high for exactly one clock, then cleared the next edge unconditionally. They are never simultaneously high.
- Acceptance: sync2 must be sampled at the new value on DEBOUNCE_CYCLES+1 consecutive edges.
  - A raw level captured into sync1 at edge k is reflected on outputX (and the pulse) at edge k+DEBOUNCE_CYCLES+2.
  - Default latency: 6 edges.
- Rejection: a raw pulse lasting <= DEBOUNCE_CYCLES clock cycles never changes outputX. A pulse lasting DEBOUNCE_CYCLES+1 cycles is accepted.
- Counter never wraps: it is cleared on every state entry and stops at DEBOUNCE_CYCLES-1.
- Reset mid-debounce (RISING/FALLING): debounce is aborted. After release, the input is re-synchronized from scratch, with full latency again.
- outputX changes only on LOW<->HIGH transitions. Outputs are held constant while in RISING/FALLING.

Test Plan:
- Reset: inputR=0 for 2 edges with inputX=1 -> outputX=0, outputRise=0, outputFall=0.
  - Then inputR=1 with inputX held 1 -> outputX=1 and outputRise=1 at the 6th edge after release; outputRise=0 on the next edge.
- Clean edge: inputX 0->1 captured at edge 10 -> outputX=1, outputRise=1 at edge 16 only.
  - Later 1->0 captured at edge 30 -> outputX=0, outputFall=1 at edge 36 only.
- Glitch rejection: from LOW, inputX high for 4 cycles then low -> outputX stays 0, no outputRise.
  - Repeat with a 5-cycle high -> outputX=1 with one outputRise.
- Bounce train: inputX toggles 1,0,1,1,0,1 (one value per cycle), then steady 1 -> exactly one outputRise.
  - It occurs 6 edges after the final 0->1 capture; no outputFall.
- Reset mid-operation: inputR=0 for one edge while in RISING with cnt=2 -> all outputs 0, state LOW.
  - With inputX still 1, outputRise follows 6 edges after release.
- Parameter sweep: DEBOUNCE_CYCLES=1, CNT_W=1 -> latency 3 edges; 1-cycle pulse rejected, 2-cycle pulse accepted.

Source files
------------

// File: rtl/input_conditioner_stage.sv
// Two-flop synchronizer plus debounce FSM for one raw external input; emits a clean
// registered level and single-cycle rise/fall pulses for the downstream Moore logic.
module input_conditioner_stage #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic inputClk,
    input  logic inputR,
    input  logic inputX,
    output logic outputX,
    output logic outputRise,
    output logic outputFall
);

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        RISING  = 2'd1,
        HIGH    = 2'd2,
        FALLING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             x_n;
    logic             rise_n;
    logic             fall_n;

    always_ff @(posedge inputClk) begin
        if (!inputR) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            state      <= LOW;
            cnt        <= '0;
            outputX    <= 1'b0;
            outputRise <= 1'b0;
            outputFall <= 1'b0;
        end else begin
            sync1      <= inputX;
            sync2      <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            outputX    <= x_n;
            outputRise <= rise_n;
            outputFall <= fall_n;
        end
    end

    // Counter is cleared on every state change and saturates at CNT_LAST, so it never wraps.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x_n     = outputX;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            LOW: begin
                if (sync2) begin
                    state_n = RISING;
                    cnt_n   = '0;
                end
            end
            RISING: begin
                if (!sync2) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    x_n     = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!sync2) begin
                    state_n = FALLING;
                    cnt_n   = '0;
                end
            end
            FALLING: begin
                if (sync2) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = LOW;
                    cnt_n   = '0;
                    x_n     = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_input_conditioner_stage.sv
// Directed bench: a segment table drives the default instance edge by edge; a short
// hand-written sequence exercises the DEBOUNCE_CYCLES=1 instance.
module tb_input_conditioner_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r1, x1, ox1, rise1, fall1;
    logic r2, x2, ox2, rise2, fall2;

    input_conditioner_stage #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .inputClk  (clk),
        .inputR    (r1),
        .inputX    (x1),
        .outputX   (ox1),
        .outputRise(rise1),
        .outputFall(fall1)
    );

    input_conditioner_stage #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut_d1 (
        .inputClk  (clk),
        .inputR    (r2),
        .inputX    (x2),
        .outputX   (ox2),
        .outputRise(rise2),
        .outputFall(fall2)
    );

    // One record = apply {r,x} for n consecutive edges; outputs must equal {ex,er,ef} after each.
    typedef struct {
        logic        r;
        logic        x;
        int unsigned n;
        logic        ex;
        logic        er;
        logic        ef;
        string       tag;
    } seg_t;

    seg_t tbl[$];
    int unsigned checks = 0;
    int unsigned fails  = 0;
    int unsigned edge_no = 0;

    function automatic void add(input logic r, input logic x, input int unsigned n,
                                input logic ex, input logic er, input logic ef, input string tag);
        seg_t s;
        s.r = r; s.x = x; s.n = n; s.ex = ex; s.er = er; s.ef = ef; s.tag = tag;
        tbl.push_back(s);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge %0d: got %b expected %b", name, edge_no, act, exp);
        end
    endtask

    task automatic step2(input logic r, input logic x, input logic ex, input logic er,
                         input logic ef, input string tag);
        @(negedge clk);
        r2 = r;
        x2 = x;
        @(posedge clk);
        edge_no++;
        #1;
        check({tag, ".x"},    ox2,   ex);
        check({tag, ".rise"}, rise2, er);
        check({tag, ".fall"}, fall2, ef);
    endtask

    initial begin
        r1 = 1'b0; x1 = 1'b1;
        r2 = 1'b0; x2 = 1'b0;

        // Reset with input high, then release: capture on first released edge, output 6 edges later.
        add(0, 1, 2, 0, 0, 0, "rst");
        add(1, 1, 6, 0, 0, 0, "rel_wait");
        add(1, 1, 1, 1, 1, 0, "rel_rise");
        add(1, 1, 4, 1, 0, 0, "rel_hold");
        // Clean falling edge.
        add(1, 0, 6, 1, 0, 0, "fall_wait");
        add(1, 0, 1, 0, 0, 1, "fall_pulse");
        add(1, 0, 3, 0, 0, 0, "fall_hold");
        // 4-cycle glitch rejected.
        add(1, 1, 4, 0, 0, 0, "glitch4_hi");
        add(1, 0, 8, 0, 0, 0, "glitch4_lo");
        // 5-cycle pulse accepted, then its trailing low is accepted too.
        add(1, 1, 5, 0, 0, 0, "pulse5_hi");
        add(1, 0, 1, 0, 0, 0, "pulse5_lo");
        add(1, 0, 1, 1, 1, 0, "pulse5_rise");
        add(1, 0, 4, 1, 0, 0, "pulse5_held");
        add(1, 0, 1, 0, 0, 1, "pulse5_fall");
        add(1, 0, 2, 0, 0, 0, "pulse5_idle");
        // Bounce train 1,0,1,1,0,1 then steady 1.
        add(1, 1, 1, 0, 0, 0, "bounce");
        add(1, 0, 1, 0, 0, 0, "bounce");
        add(1, 1, 2, 0, 0, 0, "bounce");
        add(1, 0, 1, 0, 0, 0, "bounce");
        add(1, 1, 6, 0, 0, 0, "bounce_wait");
        add(1, 1, 1, 1, 1, 0, "bounce_rise");
        add(1, 1, 4, 1, 0, 0, "bounce_hold");
        add(1, 0, 6, 1, 0, 0, "bounce_fwait");
        add(1, 0, 1, 0, 0, 1, "bounce_fall");
        add(1, 0, 3, 0, 0, 0, "bounce_idle");
        // Reset while RISING with cnt=2, then full latency again.
        add(1, 1, 5, 0, 0, 0, "mid_debounce");
        add(0, 1, 1, 0, 0, 0, "mid_rst");
        add(1, 1, 6, 0, 0, 0, "mid_wait");
        add(1, 1, 1, 1, 1, 0, "mid_rise");
        add(1, 1, 2, 1, 0, 0, "mid_hold");
        // Reset from HIGH clears the level without a fall pulse.
        add(0, 1, 1, 0, 0, 0, "rst_from_high");
        add(0, 0, 1, 0, 0, 0, "rst_idle");

        foreach (tbl[i]) begin
            for (int unsigned k = 0; k < tbl[i].n; k++) begin
                @(negedge clk);
                r1 = tbl[i].r;
                x1 = tbl[i].x;
                @(posedge clk);
                edge_no++;
                #1;
                check({tbl[i].tag, ".x"},    ox1,   tbl[i].ex);
                check({tbl[i].tag, ".rise"}, rise1, tbl[i].er);
                check({tbl[i].tag, ".fall"}, fall1, tbl[i].ef);
            end
        end

        // DEBOUNCE_CYCLES=1: latency 3, 1-cycle pulse rejected, 2-cycle pulse accepted.
        step2(0, 0, 0, 0, 0, "d1_rst");
        step2(1, 0, 0, 0, 0, "d1_idle");
        step2(1, 0, 0, 0, 0, "d1_idle");
        step2(1, 1, 0, 0, 0, "d1_p1_hi");
        for (int unsigned k = 0; k < 5; k++) step2(1, 0, 0, 0, 0, "d1_p1_lo");
        step2(1, 1, 0, 0, 0, "d1_p2_hi");
        step2(1, 1, 0, 0, 0, "d1_p2_hi");
        step2(1, 0, 0, 0, 0, "d1_p2_lo");
        step2(1, 0, 1, 1, 0, "d1_rise");
        step2(1, 0, 1, 0, 0, "d1_held");
        step2(1, 0, 0, 0, 1, "d1_fall");
        step2(1, 0, 0, 0, 0, "d1_idle2");
        step2(1, 0, 0, 0, 0, "d1_idle2");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
